// File: rtl/uart_prog_loader_if.sv
// Instruction-RAM write port driven by the program loader.
// The loader uses the master view; the RAM (or a bench) uses the slave view.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic              upg_wen;
    logic [ADDR_W-1:0] upg_addr;
    logic [31:0]       upg_data;

    modport master (output upg_wen, upg_addr, upg_data);
    modport slave  (input  upg_wen, upg_addr, upg_data);
endinterface

// File: rtl/uart_prog_loader.sv
// UART byte-stream program loader: frames SYNC/LEN_LO/LEN_HI/data, assembles little-endian
// 32-bit words and writes them to instruction RAM; upg_done_o releases the fetch stage.
module uart_prog_loader #(
    parameter int          ADDR_W      = 14,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    uart_prog_loader_if.master    upg,
    output logic                  upg_done_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'((2 ** ADDR_W) / 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg;
    logic [7:0]        len_lo_reg;
    logic [15:0]       words_left_reg;
    logic [1:0]        byte_idx_reg;
    logic [23:0]       word_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [TMO_W-1:0]  tmo_reg;

    logic [16:0] len_full;
    logic        tmo_expired;

    assign len_full    = {1'b0, rx_data_i, len_lo_reg};
    // Fires on the TIMEOUT_CYC-th consecutive silent cycle inside a frame.
    assign tmo_expired = !rx_valid_i && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            len_lo_reg     <= '0;
            words_left_reg <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            addr_reg       <= '0;
            tmo_reg        <= '0;
            upg.upg_wen    <= 1'b0;
            upg.upg_addr   <= '0;
            upg.upg_data   <= '0;
            upg_done_o     <= 1'b1;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            upg.upg_wen <= 1'b0;
            if (start_i) begin
                // Restart from any state; a coincident byte is deliberately dropped.
                state_reg    <= S_WAIT_SYNC;
                addr_reg     <= '0;
                byte_idx_reg <= '0;
                tmo_reg      <= '0;
                upg_done_o   <= 1'b0;
                busy_o       <= 1'b1;
                err_o        <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                    end
                    S_WAIT_SYNC: begin
                        if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
                            state_reg <= S_LEN_LO;
                            tmo_reg   <= '0;
                        end
                    end
                    S_LEN_LO: begin
                        if (rx_valid_i) begin
                            len_lo_reg <= rx_data_i;
                            state_reg  <= S_LEN_HI;
                            tmo_reg    <= '0;
                        end else if (tmo_expired) begin
                            state_reg <= S_ERR;
                            busy_o    <= 1'b0;
                            err_o     <= 1'b1;
                        end else begin
                            tmo_reg <= tmo_reg + TMO_W'(1);
                        end
                    end
                    S_LEN_HI: begin
                        if (rx_valid_i) begin
                            tmo_reg <= '0;
                            if (len_full == 17'd0 || len_full > MAX_WORDS) begin
                                state_reg <= S_ERR;
                                busy_o    <= 1'b0;
                                err_o     <= 1'b1;
                            end else begin
                                words_left_reg <= len_full[15:0];
                                byte_idx_reg   <= '0;
                                state_reg      <= S_DATA;
                            end
                        end else if (tmo_expired) begin
                            state_reg <= S_ERR;
                            busy_o    <= 1'b0;
                            err_o     <= 1'b1;
                        end else begin
                            tmo_reg <= tmo_reg + TMO_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (rx_valid_i) begin
                            tmo_reg      <= '0;
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            if (byte_idx_reg == 2'd3) begin
                                upg.upg_wen    <= 1'b1;
                                upg.upg_addr   <= addr_reg;
                                upg.upg_data   <= {rx_data_i, word_reg};
                                addr_reg       <= addr_reg + ADDR_W'(4);
                                words_left_reg <= words_left_reg - 16'd1;
                                if (words_left_reg == 16'd1) begin
                                    state_reg <= S_DONE;
                                    busy_o    <= 1'b0;
                                end
                            end else begin
                                word_reg[{byte_idx_reg, 3'b000} +: 8] <= rx_data_i;
                            end
                        end else if (tmo_expired) begin
                            state_reg <= S_ERR;
                            busy_o    <= 1'b0;
                            err_o     <= 1'b1;
                        end else begin
                            tmo_reg <= tmo_reg + TMO_W'(1);
                        end
                    end
                    S_DONE: begin
                        // Fetch is released the cycle after the final write pulse.
                        state_reg  <= S_IDLE;
                        upg_done_o <= 1'b1;
                    end
                    S_ERR: begin
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomised scoreboard bench for uart_prog_loader: frames are built from word lists, the expected
// RAM writes are queued at stimulus time and a forked monitor checks every write pulse.
module tb_uart_prog_loader;
    localparam int ADDR_W = 14;
    localparam int TMO    = 100;
    localparam int MAXW   = (2 ** ADDR_W) / 4;

    logic       clk_i      = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start_i    = 1'b0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i  = 8'h00;
    logic       upg_done_o;
    logic       busy_o;
    logic       err_o;

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) upg_bus ();

    uart_prog_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .upg        (upg_bus.master),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    int         tests  = 0;
    int         failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask

    // Sends byte_q; the final byte always gets gap 0 so the write pulse is visible on return.
    task automatic send_q(input int gap);
        for (int i = 0; i < byte_q.size(); i++)
            send_byte(byte_q[i], (i == byte_q.size() - 1) ? 0 : gap);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic frame_end_checks();
        chk("done_low_on_last_pulse", upg_done_o, 1'b0);
        @(negedge clk_i);
        chk("done_after_frame", upg_done_o, 1'b1);
        chk("busy_after_frame", busy_o, 1'b0);
        chk("err_after_frame", err_o, 1'b0);
        chk("writes_outstanding", exp_q.size(), 0);
    endtask

    // Reference: N words go to byte addresses 0,4,..,4(N-1), each sent LSB first after A5/N_lo/N_hi.
    task automatic send_frame(input int n, input int junk, input int maxgap);
        logic [31:0] w;
        logic [7:0]  b;
        for (int i = 0; i < junk; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, $urandom_range(0, maxgap));
        end
        send_byte(8'hA5, $urandom_range(0, maxgap));
        send_byte(8'(n), $urandom_range(0, maxgap));
        send_byte(8'(n >> 8), $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: ADDR_W'(4 * i), data: w});
            for (int k = 0; k < 4; k++)
                send_byte(8'(w >> (8 * k)), (i == n - 1 && k == 3) ? 0 : $urandom_range(0, maxgap));
        end
        $display("[TB] frame n=%0d junk=%0d sent", n, junk);
        frame_end_checks();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        wr_t e;
        int  cnt;
        fork
            forever begin
                @(negedge clk_i);
                if (upg_bus.upg_wen === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                                 upg_bus.upg_addr, upg_bus.upg_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(upg_bus.upg_addr), 32'(e.addr));
                        chk("wr_data", upg_bus.upg_data, e.data);
                    end
                end
            end
        join_none

        // Reset and idle
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        chk("rst_done", upg_done_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_wen", upg_bus.upg_wen, 1'b0);
        chk("rst_addr", 32'(upg_bus.upg_addr), 0);
        chk("rst_data", upg_bus.upg_data, 0);
        repeat (10) @(negedge clk_i);
        chk("idle_done", upg_done_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);
        $display("[TB] reset/idle checked");

        // Two-word frame with spaced strobes
        pulse_start();
        chk("start_busy", busy_o, 1'b1);
        chk("start_done", upg_done_o, 1'b0);
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h0000_0013});
        exp_q.push_back('{addr: ADDR_W'(4), data: 32'h0010_0093});
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_q(1);
        $display("[TB] frame two-word sent");
        frame_end_checks();

        // Junk before sync, back-to-back strobes
        pulse_start();
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'hDEAD_BEEF});
        byte_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_q(0);
        $display("[TB] frame deadbeef sent");
        frame_end_checks();

        // Oversized length, then zero length
        pulse_start();
        byte_q = '{8'hA5, 8'h01, 8'h10};
        send_q(0);
        chk("len4097_err", err_o, 1'b1);
        chk("len4097_done", upg_done_o, 1'b0);
        chk("len4097_busy", busy_o, 1'b0);
        repeat (5) @(negedge clk_i);
        chk("err_sticky", err_o, 1'b1);
        pulse_start();
        chk("restart_err_clear", err_o, 1'b0);
        chk("restart_busy", busy_o, 1'b1);
        byte_q = '{8'hA5, 8'h00, 8'h00};
        send_q(0);
        chk("len0_err", err_o, 1'b1);
        $display("[TB] length errors sent");

        // Restart mid-DATA with a coincident sync byte that must be discarded
        pulse_start();
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h7654_3210});
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h32, 8'h54, 8'h76, 8'h99, 8'h88};
        send_q(0);
        start_i    = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hA5;
        @(negedge clk_i);
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        chk("restart_mid_busy", busy_o, 1'b1);
        chk("restart_mid_done", upg_done_o, 1'b0);
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h4433_2211});
        byte_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_q(0);
        $display("[TB] frame after mid-data restart sent");
        frame_end_checks();

        // Timeout in DATA after one word
        pulse_start();
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'hCAFE_F00D});
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_q(0);
        cnt = 0;
        while (err_o !== 1'b1 && cnt < 300) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("timeout_cycles", cnt, TMO);
        chk("timeout_err", err_o, 1'b1);
        chk("timeout_done", upg_done_o, 1'b0);
        chk("timeout_busy", busy_o, 1'b0);
        chk("timeout_pending", exp_q.size(), 0);
        $display("[TB] timeout frame sent");

        // Randomised frames; bytes sent while idle must be ignored
        for (int it = 0; it < 20; it++) begin
            if (it % 4 == 0) begin
                byte_q = '{8'hA5, 8'h01, 8'h00, 8'(it), 8'h5A, 8'h00, 8'h77};
                send_q(0);
                chk("idle_bytes_busy", busy_o, 1'b0);
            end
            pulse_start();
            send_frame($urandom_range(1, 6), $urandom_range(0, 3), 3);
        end

        // Largest legal frame, back-to-back
        pulse_start();
        send_frame(MAXW, 0, 0);

        repeat (5) @(negedge clk_i);
        chk("final_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
